ad_ip_jesd204_link_upconv: RTL and testbench

//  Up-converts link beat rate by 2 by halving datawidth: each wide input beat
//  (NUM_LANES x OCTETS_PER_BEAT_IN) is emitted as two narrow output beats on the

---
 rtl/ad_ip_jesd204_link_upconv_pkg.sv | 11 +
 rtl/ad_ip_jesd204_link_upconv_buf.sv | 75 +++++++
 rtl/ad_ip_jesd204_link_upconv.sv | 65 ++++++
 tb/tb_ad_ip_jesd204_link_upconv.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_link_upconv_pkg.sv
// Shared constants for the JESD204 link beat-rate up-converter.
// Beat widths are derived from octet counts through the helper below.
package ad_ip_jesd204_link_upconv_pkg;

   localparam int unsigned OctetW = 8;

   function automatic int unsigned beat_w(input int unsigned octets);
      return OctetW * octets;
   endfunction

endpackage

// File: rtl/ad_ip_jesd204_link_upconv_buf.sv
// Two-entry ping-pong buffer of wide beats with a registered write-ready.
// Each entry is read twice (phase 0 then phase 1) before it is released.
module ad_ip_jesd204_link_upconv_buf #(
   parameter int unsigned EntryW = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic [EntryW-1:0] wr_data_i,
   input  logic              rd_ready_i,
   output logic              rd_valid_o,
   output logic              rd_phase_o,
   output logic [EntryW-1:0] rd_data_o
);

   logic [EntryW-1:0] mem_q [2];
   logic [EntryW-1:0] mem_d [2];
   logic [1:0]        count_q, count_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              phase_q, phase_d;
   logic              ready_q, ready_d;
   logic              push, pop, pop_last;

   assign push     = wr_valid_i & ready_q;
   assign pop      = (count_q != 2'd0) & rd_ready_i;
   assign pop_last = pop & phase_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      phase_d  = phase_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data_i;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         phase_d = ~phase_q;
      end
      if (pop_last) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop_last);
      // Ready looks one cycle ahead so upstream never sees a combinational path.
      ready_d = (count_d < 2'd2);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         phase_q  <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         phase_q  <= phase_d;
         ready_q  <= ready_d;
      end
   end

   assign wr_ready_o = ready_q;
   assign rd_valid_o = (count_q != 2'd0);
   assign rd_phase_o = phase_q;
   assign rd_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ad_ip_jesd204_link_upconv.sv
// Halves per-lane datapath width: every wide beat leaves as two narrow beats,
// low (older) octets of each lane first, high octets second.
module ad_ip_jesd204_link_upconv
   import ad_ip_jesd204_link_upconv_pkg::*;
#(
   parameter int unsigned NUM_LANES           = 4,
   parameter int unsigned OCTETS_PER_BEAT_IN  = 8,
   parameter int unsigned OCTETS_PER_BEAT_OUT = OCTETS_PER_BEAT_IN / 2
) (
   input  logic                                            link_clk,
   input  logic                                            link_resetn,
   input  logic [OCTETS_PER_BEAT_IN-1:0]                   in_link_sof,
   input  logic                                            in_link_valid,
   output logic                                            in_link_ready,
   input  logic [NUM_LANES*OctetW*OCTETS_PER_BEAT_IN-1:0]  in_link_data,
   output logic [OCTETS_PER_BEAT_OUT-1:0]                  out_link_sof,
   output logic                                            out_link_valid,
   input  logic                                            out_link_ready,
   output logic [NUM_LANES*OctetW*OCTETS_PER_BEAT_OUT-1:0] out_link_data
);

   localparam int unsigned IBW    = beat_w(OCTETS_PER_BEAT_IN);
   localparam int unsigned OBW    = beat_w(OCTETS_PER_BEAT_OUT);
   localparam int unsigned DataW  = NUM_LANES * IBW;
   localparam int unsigned EntryW = OCTETS_PER_BEAT_IN + DataW;

   logic [EntryW-1:0]             rd_entry;
   logic [DataW-1:0]              rd_data;
   logic [OCTETS_PER_BEAT_IN-1:0] rd_sof;
   logic                          rd_valid;
   logic                          rd_phase;

   ad_ip_jesd204_link_upconv_buf #(
      .EntryW (EntryW)
   ) u_buf (
      .clk_i      (link_clk),
      .rst_ni     (link_resetn),
      .wr_valid_i (in_link_valid),
      .wr_ready_o (in_link_ready),
      .wr_data_i  ({in_link_sof, in_link_data}),
      .rd_ready_i (out_link_ready),
      .rd_valid_o (rd_valid),
      .rd_phase_o (rd_phase),
      .rd_data_o  (rd_entry)
   );

   assign rd_data        = rd_entry[DataW-1:0];
   assign rd_sof         = rd_entry[EntryW-1:DataW];
   assign out_link_valid = rd_valid;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign out_link_data[OBW*i +: OBW] = rd_phase ? rd_data[IBW*i+OBW +: OBW]
                                                    : rd_data[IBW*i +: OBW];
   end

   // Sof is masked when idle so a stale entry never flags a frame start.
   always_comb begin
      out_link_sof = '0;
      if (rd_valid) begin
         out_link_sof = rd_phase ? rd_sof[OCTETS_PER_BEAT_IN-1:OCTETS_PER_BEAT_OUT]
                                 : rd_sof[OCTETS_PER_BEAT_OUT-1:0];
      end
   end

endmodule

// File: tb/tb_ad_ip_jesd204_link_upconv.sv
// Directed and randomized bench for the 2:1 link up-converter
// (2 lanes, 4 octets in, 2 octets out).
module tb_ad_ip_jesd204_link_upconv;

   logic        link_clk = 1'b0;
   logic        link_resetn;
   logic [3:0]  in_link_sof;
   logic        in_link_valid;
   logic        in_link_ready;
   logic [63:0] in_link_data;
   logic [1:0]  out_link_sof;
   logic        out_link_valid;
   logic        out_link_ready;
   logic [31:0] out_link_data;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned n_acc = 0;
   int unsigned n_out = 0;
   logic [33:0] q [$];

   localparam logic [63:0] DataA = 64'hB3B2B1B0_A3A2A1A0;
   localparam logic [63:0] DataB = 64'hD3D2D1D0_C3C2C1C0;
   localparam logic [63:0] DataC = 64'hF3F2F1F0_E3E2E1E0;

   ad_ip_jesd204_link_upconv #(
      .NUM_LANES           (2),
      .OCTETS_PER_BEAT_IN  (4),
      .OCTETS_PER_BEAT_OUT (2)
   ) dut (
      .link_clk       (link_clk),
      .link_resetn    (link_resetn),
      .in_link_sof    (in_link_sof),
      .in_link_valid  (in_link_valid),
      .in_link_ready  (in_link_ready),
      .in_link_data   (in_link_data),
      .out_link_sof   (out_link_sof),
      .out_link_valid (out_link_valid),
      .out_link_ready (out_link_ready),
      .out_link_data  (out_link_data)
   );

   always #5 link_clk = ~link_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Narrow beat {sof, lane1, lane0} expected from a wide beat.
   function automatic logic [33:0] narrow(input logic [63:0] d, input logic [3:0] s,
                                          input bit ph);
      if (!ph) return {s[1:0], d[47:32], d[15:0]};
      return {s[3:2], d[63:48], d[31:16]};
   endfunction

   // Called at a negative edge: drive, check against the model, advance one cycle.
   task automatic step(input logic iv, input logic [63:0] d, input logic [3:0] s,
                       input logic ordy);
      in_link_valid  = iv;
      in_link_data   = d;
      in_link_sof    = s;
      out_link_ready = ordy;
      #1;
      chk("valid_vs_model", 64'(out_link_valid), 64'(q.size() != 0));
      if (out_link_valid && q.size() != 0) begin
         chk("beat", {30'd0, out_link_sof, out_link_data}, {30'd0, q[0]});
         if (ordy) begin
            void'(q.pop_front());
            n_out++;
         end
      end else begin
         chk("idle_sof", 64'(out_link_sof), 64'd0);
      end
      if (iv && in_link_ready) begin
         q.push_back(narrow(d, s, 1'b0));
         q.push_back(narrow(d, s, 1'b1));
         n_acc++;
      end
      @(negedge link_clk);
   endtask

   task automatic drain(input int unsigned bound);
      int unsigned c = 0;
      while (q.size() != 0 && c < bound) begin
         step(1'b0, 64'd0, 4'd0, 1'b1);
         c++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      int unsigned a0, o0, cyc;
      link_resetn    = 1'b0;
      in_link_valid  = 1'b0;
      in_link_data   = '0;
      in_link_sof    = '0;
      out_link_ready = 1'b0;

      // Reset state
      @(negedge link_clk);
      chk("rst_in_ready", 64'(in_link_ready), 64'd0);
      chk("rst_out_valid", 64'(out_link_valid), 64'd0);
      chk("rst_out_sof", 64'(out_link_sof), 64'd0);
      chk("rst_out_data", 64'(out_link_data), 64'd0);
      link_resetn = 1'b1;
      @(negedge link_clk);
      chk("post_rst_ready", 64'(in_link_ready), 64'd1);

      // Single beat, sof in octet 0
      step(1'b1, DataA, 4'b0001, 1'b1);
      chk("single_b0_data", 64'(out_link_data), 64'h00000000_B1B0A1A0);
      chk("single_b0_sof", 64'(out_link_sof), 64'd1);
      step(1'b0, 64'd0, 4'd0, 1'b1);
      chk("single_b1_data", 64'(out_link_data), 64'h00000000_B3B2A3A2);
      chk("single_b1_sof", 64'(out_link_sof), 64'd0);
      step(1'b0, 64'd0, 4'd0, 1'b1);
      chk("single_done", 64'(out_link_valid), 64'd0);

      // Sof in upper octets shows only on phase 1
      step(1'b1, DataB, 4'b0100, 1'b1);
      chk("sof_hi_b0_sof", 64'(out_link_sof), 64'd0);
      chk("sof_hi_b0_data", 64'(out_link_data), 64'h00000000_D1D0C1C0);
      step(1'b0, 64'd0, 4'd0, 1'b1);
      chk("sof_hi_b1_sof", 64'(out_link_sof), 64'd1);
      step(1'b0, 64'd0, 4'd0, 1'b1);

      // Continuous stream: 100 wide beats, no bubbles
      a0 = n_acc;
      o0 = n_out;
      cyc = 0;
      while (n_acc - a0 < 100 && cyc < 400) begin
         step(1'b1, {$urandom, $urandom}, 4'($urandom), 1'b1);
         cyc++;
      end
      while (q.size() != 0 && cyc < 500) begin
         step(1'b0, 64'd0, 4'd0, 1'b1);
         cyc++;
      end
      chk("stream_out_count", 64'(n_out - o0), 64'd200);
      chk("stream_cycles", 64'(cyc), 64'd201);

      // Backpressure: output stalled after pushes
      o0 = n_out;
      step(1'b1, DataA, 4'b0001, 1'b0);
      step(1'b1, DataB, 4'b0010, 1'b0);
      chk("full_in_ready", 64'(in_link_ready), 64'd0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, DataC, 4'b1000, 1'b0);
      end
      chk("full_frozen_data", 64'(out_link_data), 64'h00000000_B1B0A1A0);
      chk("full_frozen_sof", 64'(out_link_sof), 64'd1);
      chk("full_frozen_in_ready", 64'(in_link_ready), 64'd0);
      a0 = n_acc;
      cyc = 0;
      while (n_acc == a0 && cyc < 10) begin
         step(1'b1, DataC, 4'b1000, 1'b1);
         cyc++;
      end
      chk("bp_third_accepted", 64'(n_acc - a0), 64'd1);
      drain(20);
      chk("bp_out_count", 64'(n_out - o0), 64'd6);

      // Random valid/ready, 10k wide beats
      a0 = n_acc;
      o0 = n_out;
      cyc = 0;
      while (n_acc - a0 < 10000 && cyc < 70000) begin
         step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom),
              1'($urandom_range(0, 1)));
         cyc++;
      end
      chk("rand_accepted", 64'(n_acc - a0), 64'd10000);
      drain(50);
      chk("rand_out_count", 64'(n_out - o0), 64'd20000);
      chk("rand_idle", 64'(out_link_valid), 64'd0);

      // Reset with count=2, phase=1
      step(1'b1, DataA, 4'b0000, 1'b0);
      step(1'b1, DataB, 4'b0000, 1'b0);
      step(1'b0, 64'd0, 4'd0, 1'b1);
      chk("pre_rst_valid", 64'(out_link_valid), 64'd1);
      chk("pre_rst_phase1", 64'(out_link_data), 64'h00000000_B3B2A3A2);
      link_resetn = 1'b0;
      #1;
      chk("midrst_valid", 64'(out_link_valid), 64'd0);
      chk("midrst_ready", 64'(in_link_ready), 64'd0);
      chk("midrst_data", 64'(out_link_data), 64'd0);
      q.delete();
      @(negedge link_clk);
      link_resetn = 1'b1;
      step(1'b0, 64'd0, 4'd0, 1'b1);
      chk("after_rst_ready", 64'(in_link_ready), 64'd1);
      step(1'b1, DataC, 4'b0011, 1'b1);
      chk("after_rst_b0_data", 64'(out_link_data), 64'h00000000_F1F0E1E0);
      chk("after_rst_b0_sof", 64'(out_link_sof), 64'd3);
      step(1'b0, 64'd0, 4'd0, 1'b1);
      chk("after_rst_b1_data", 64'(out_link_data), 64'h00000000_F3F2E3E2);
      chk("after_rst_b1_sof", 64'(out_link_sof), 64'd0);
      step(1'b0, 64'd0, 4'd0, 1'b1);
      chk("after_rst_idle", 64'(out_link_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
